// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray/binary pointer conversions shared by both FIFO pointer blocks
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] width_mask(input int w);
    logic [MAX_PTR_W-1:0] m;
    if (w >= MAX_PTR_W)
      m = '1;
    else
      m = (MAX_PTR_W'(1) << w) - MAX_PTR_W'(1);
    return m;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b, input int w);
    logic [MAX_PTR_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g, input int w);
    logic [MAX_PTR_W-1:0] gm;
    logic [MAX_PTR_W-1:0] r;
    gm = g & width_mask(w);
    r  = '0;
    for (int i = 0; i < MAX_PTR_W; i++)
      r[i] = ^(gm >> i);
    return r;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rd_pntrs_and_empty.sv
// rtl/rd_pntrs_and_empty.sv - read pointer, synchronized write pointer, empty flag and fill level
module rd_pntrs_and_empty
  import fifo_pkg::*;
#(
  parameter int AWIDTH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            rd_clk_i,
  input  logic            srst_i,
  input  logic            rd_req_i,
  input  logic [AWIDTH:0] wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic [AWIDTH:0] rd_pntr_gray_wr_o,
  output logic            rd_empty_o,
  output logic [AWIDTH:0] rd_usedw_o
);

  localparam int PTR_W = AWIDTH + 1;

  logic [AWIDTH:0] rd_pntr_bin;
  logic [AWIDTH:0] rd_pntr_bin_next;
  logic [AWIDTH:0] rd_pntr_gray_next;
  logic [AWIDTH:0] wr_gray_sync;
  logic [AWIDTH:0] wr_bin_sync;
  logic            rd_en;

  gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk  (rd_clk_i),
    .srst (srst_i),
    .d    (wr_pntr_gray_i),
    .q    (wr_gray_sync)
  );

  // Flags come from next-state values so a read of the last word raises empty on the same edge.
  assign rd_en             = rd_req_i & ~rd_empty_o;
  assign rd_pntr_bin_next  = rd_pntr_bin + PTR_W'(rd_en);
  assign rd_pntr_gray_next = PTR_W'(bin2gray(MAX_PTR_W'(rd_pntr_bin_next), PTR_W));
  assign wr_bin_sync       = PTR_W'(gray2bin(MAX_PTR_W'(wr_gray_sync), PTR_W));

  always_ff @(posedge rd_clk_i) begin
    if (srst_i) begin
      rd_pntr_bin       <= '0;
      rd_pntr_gray_wr_o <= '0;
      rd_empty_o        <= 1'b1;
      rd_usedw_o        <= '0;
    end else begin
      rd_pntr_bin       <= rd_pntr_bin_next;
      rd_pntr_gray_wr_o <= rd_pntr_gray_next;
      rd_empty_o        <= (rd_pntr_gray_next == wr_gray_sync);
      rd_usedw_o        <= wr_bin_sync - rd_pntr_bin_next;
    end
  end

  assign rd_pntr_o = rd_pntr_bin[AWIDTH-1:0];

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// tb/tb_rd_pntrs_and_empty.sv - directed self-checking bench for rd_pntrs_and_empty
module tb_rd_pntrs_and_empty;

  logic       rd_clk_i;
  logic       srst_i;
  logic       rd_req_i;
  logic [4:0] wr_pntr_gray_i;
  logic [3:0] rd_pntr_o;
  logic [4:0] rd_pntr_gray_wr_o;
  logic       rd_empty_o;
  logic [4:0] rd_usedw_o;

  int n_checks = 0;
  int n_pass   = 0;

  rd_pntrs_and_empty #(
    .AWIDTH      (4),
    .SYNC_STAGES (2)
  ) dut (
    .rd_clk_i          (rd_clk_i),
    .srst_i            (srst_i),
    .rd_req_i          (rd_req_i),
    .wr_pntr_gray_i    (wr_pntr_gray_i),
    .rd_pntr_o         (rd_pntr_o),
    .rd_pntr_gray_wr_o (rd_pntr_gray_wr_o),
    .rd_empty_o        (rd_empty_o),
    .rd_usedw_o        (rd_usedw_o)
  );

  initial rd_clk_i = 1'b0;
  always #5 rd_clk_i = ~rd_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge rd_clk_i);
    #1;
  endtask

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] b5(input logic [4:0] g);
    logic [4:0] r;
    r[4] = g[4];
    for (int i = 3; i >= 0; i--)
      r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  // Reference model state for the random wrap-around section
  int         r_cnt;
  int         w_cnt;
  logic [4:0] s0_m, s1_m;
  logic       emp_m;
  logic [4:0] used_m;
  int         msb_toggles;
  logic       last_msb;
  int         cyc;

  initial begin
    srst_i         = 1'b1;
    rd_req_i       = 1'b1;
    wr_pntr_gray_i = 5'b00000;
    tick();
    tick();
    check("rst_empty", 32'(rd_empty_o), 1);
    check("rst_usedw", 32'(rd_usedw_o), 0);
    check("rst_ptr", 32'(rd_pntr_o), 0);
    check("rst_gray", 32'(rd_pntr_gray_wr_o), 0);

    // Single word: visible three edges after the write pointer changes
    srst_i         = 1'b0;
    rd_req_i       = 1'b0;
    wr_pntr_gray_i = 5'b00001;
    tick();
    tick();
    check("sw_empty_pessimistic", 32'(rd_empty_o), 1);
    tick();
    check("sw_empty", 32'(rd_empty_o), 0);
    check("sw_usedw", 32'(rd_usedw_o), 1);
    rd_req_i = 1'b1;
    tick();
    check("sw_rd_ptr", 32'(rd_pntr_o), 1);
    check("sw_rd_gray", 32'(rd_pntr_gray_wr_o), 1);
    check("sw_rd_empty", 32'(rd_empty_o), 1);
    check("sw_rd_usedw", 32'(rd_usedw_o), 0);

    // Reads while empty are ignored
    for (int i = 0; i < 10; i++) begin
      tick();
      check("re_ptr", 32'(rd_pntr_o), 1);
      check("re_gray", 32'(rd_pntr_gray_wr_o), 1);
      check("re_usedw", 32'(rd_usedw_o), 0);
      check("re_empty", 32'(rd_empty_o), 1);
    end

    // Full depth from a clean reset
    srst_i   = 1'b1;
    rd_req_i = 1'b0;
    tick();
    check("fd_rst_ptr", 32'(rd_pntr_o), 0);
    srst_i         = 1'b0;
    wr_pntr_gray_i = 5'b11000;
    tick();
    tick();
    tick();
    check("fd_usedw", 32'(rd_usedw_o), 16);
    check("fd_empty", 32'(rd_empty_o), 0);
    rd_req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("fd_ptr", 32'(rd_pntr_o), 32'((i + 1) % 16));
      check("fd_usedw_step", 32'(rd_usedw_o), 32'(15 - i));
      check("fd_empty_step", 32'(rd_empty_o), 32'(i == 15));
    end
    check("fd_gray", 32'(rd_pntr_gray_wr_o), 32'h18);
    rd_req_i = 1'b0;

    // Wrap-around: 40 more words against a cycle model
    r_cnt       = 16;
    w_cnt       = 16;
    s0_m        = 5'b11000;
    s1_m        = 5'b11000;
    emp_m       = 1'b1;
    used_m      = 5'd0;
    msb_toggles = 0;
    last_msb    = rd_pntr_gray_wr_o[4];
    cyc         = 0;
    while (r_cnt != 56 && cyc < 3000) begin
      logic       en;
      logic [4:0] rn;
      if (w_cnt < 56 && (w_cnt - r_cnt) < 16 && ($urandom % 2 == 0))
        w_cnt++;
      wr_pntr_gray_i = g5(5'(w_cnt));
      rd_req_i       = 1'($urandom % 2);
      en     = rd_req_i & ~emp_m;
      rn     = 5'(r_cnt) + 5'(en);
      used_m = b5(s1_m) - rn;
      emp_m  = (g5(rn) == s1_m);
      s1_m   = s0_m;
      s0_m   = wr_pntr_gray_i;
      r_cnt  = r_cnt + int'(en);
      tick();
      check("wr_usedw", 32'(rd_usedw_o), 32'(used_m));
      check("wr_empty", 32'(rd_empty_o), 32'(emp_m));
      check("wr_gray", 32'(rd_pntr_gray_wr_o), 32'(g5(5'(r_cnt))));
      if (rd_pntr_gray_wr_o[4] != last_msb)
        msb_toggles++;
      last_msb = rd_pntr_gray_wr_o[4];
      cyc++;
    end
    check("wr_drained", 32'(r_cnt), 56);
    check("wr_msb_toggles", 32'(msb_toggles), 2);

    // Mid-operation reset with five words held
    rd_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_cnt++;
      wr_pntr_gray_i = g5(5'(w_cnt));
      tick();
    end
    tick();
    tick();
    tick();
    check("mr_usedw_before", 32'(rd_usedw_o), 5);
    srst_i   = 1'b1;
    rd_req_i = 1'b1;
    tick();
    check("mr_ptr", 32'(rd_pntr_o), 0);
    check("mr_gray", 32'(rd_pntr_gray_wr_o), 0);
    check("mr_empty", 32'(rd_empty_o), 1);
    check("mr_usedw", 32'(rd_usedw_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rd_pntrs_and_empty.md
# rd_pntrs_and_empty

Read-side pointer and empty-flag logic for the dual-clock FIFO, running entirely in the read clock domain. It sits opposite the write-side pointer/full block. It owns the read pointer (binary for RAM addressing, registered Gray for the write side) and synchronizes the write-side Gray pointer into the read domain. From that it produces a registered empty flag and a registered fill level.

## Interface
Parameters:
- AWIDTH, 4, RAM address width; FIFO depth = 2**AWIDTH; pointers are AWIDTH+1 bits.
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal range ≥ 2.

Ports:
- rd_clk_i  input  1  read-domain clock; the block's only clock.
- srst_i  input  1  reset; synchronous, active-high.
- rd_req_i  input  1  read request; honoured only when rd_empty_o = 0.
- wr_pntr_gray_i  input  AWIDTH+1  write pointer, Gray code, registered in write domain (asynchronous to rd_clk_i).
- rd_pntr_o  output  AWIDTH  RAM read address = rd_pntr_bin[AWIDTH-1:0].
- rd_pntr_gray_wr_o  output  AWIDTH+1  registered Gray read pointer, to the write-side synchronizer.
- rd_empty_o  output  1  registered empty flag.
- rd_usedw_o  output  AWIDTH+1  registered words held, 0..2**AWIDTH.

## Operation
- Internal state: rd_pntr_bin (AWIDTH+1), rd_pntr_gray_wr_o, synchronizer chain, rd_empty_o, rd_usedw_o.
- Reset values (srst_i = 1 at an edge): rd_pntr_bin = 0, rd_pntr_o = 0, rd_pntr_gray_wr_o = 0, all synchronizer flops = 0, rd_empty_o = 1, rd_usedw_o = 0. Reset overrides rd_req_i in the same cycle.
- rd_pntr_bin_next = rd_pntr_bin + (rd_req_i & ~rd_empty_o). Arithmetic is modulo 2**(AWIDTH+1), so wrap-around is natural.
- rd_pntr_gray_next = rd_pntr_bin_next ^ (rd_pntr_bin_next >> 1). It is registered into rd_pntr_gray_wr_o.
- wr_gray_sync = last stage of the synchronizer. wr_bin_sync = Gray-to-binary conversion of wr_gray_sync, covering all AWIDTH+1 bits.
- Empty: rd_empty_o <= (rd_pntr_gray_next == wr_gray_sync).
- Fill level: rd_usedw_o <= (wr_bin_sync - rd_pntr_bin_next) mod 2**(AWIDTH+1). It is consistent with rd_empty_o: rd_usedw_o == 0 exactly when rd_empty_o == 1.
- Read while empty: ignored; pointers, Gray output and flags hold.
- Full FIFO (pointers differ only in the MSB): rd_usedw_o = 2**AWIDTH and rd_empty_o = 0; reads proceed normally.
- Reset mid-operation: the block returns to reset values on the next edge. The write-side block must be reset in the same window; this block does not arbitrate cross-domain reset.
- Flags are pessimistic. rd_empty_o may stay high for up to SYNC_STAGES+1 cycles after a write, and never falsely deasserts.

## Timing
- Read accepted at edge N (rd_req_i = 1, rd_empty_o = 0 before edge N):
  - rd_pntr_o and rd_pntr_gray_wr_o update at edge N.
  - RAM data for the old address is the consumer's responsibility.
  - rd_empty_o and rd_usedw_o reflect the read at edge N; zero-cycle flag latency on the read side.
- Change on wr_pntr_gray_i before edge K:
  - First sync stage captures it at edge K.
  - The last stage holds it after edge K+SYNC_STAGES-1.
  - rd_empty_o and rd_usedw_o reflect it after edge K+SYNC_STAGES (3 edges for SYNC_STAGES = 2).
- Back-to-back reads are sustained at 1 per cycle while non-empty. The last word's read asserts rd_empty_o on the same edge, so no over-read is possible.
- Simultaneous read and synchronized write update in one cycle: both are applied, with usedw computed from next values.

## Structure
- Shared package fifo_pkg:
  - function bin2gray, parameterized by width.
  - function gray2bin, parameterized by width; bit i = XOR of gray bits [MSB:i].
  - The write-side block uses the same functions.
- Sub-module gray_sync: a SYNC_STAGES-deep flop chain, width AWIDTH+1, with synchronous active-high reset. Mark it for synthesis/CDC tools as a synchronizer (ASYNC_REG).
- Everything else is flat in rd_pntrs_and_empty.

## Test plan
All scenarios use AWIDTH = 4 and SYNC_STAGES = 2.
- Reset: srst_i high 2 cycles with rd_req_i = 1 -> rd_empty_o = 1, rd_usedw_o = 0, rd_pntr_o = 0, rd_pntr_gray_wr_o = 5'b00000.
- Single word: wr_pntr_gray_i 0 -> 5'b00001 -> after 3rd edge rd_empty_o = 0, rd_usedw_o = 1. One-cycle rd_req_i -> rd_pntr_o = 1, rd_pntr_gray_wr_o = 5'b00001, rd_empty_o = 1, rd_usedw_o = 0 on the same edge.
- Read while empty: rd_req_i held high 10 cycles with no write -> rd_pntr_o, rd_pntr_gray_wr_o, rd_usedw_o unchanged.
- Full depth: wr_pntr_gray_i = 5'b11000 (bin 16) -> rd_usedw_o = 16, rd_empty_o = 0. Then 16 continuous reads -> rd_pntr_o steps 0..15 and wraps to 0, rd_pntr_gray_wr_o = 5'b11000, rd_empty_o = 1.
- Wrap-around: 40 words with write pointer stepped Gray-correctly and random rd_req_i -> rd_usedw_o matches a reference model every cycle, pointer MSB toggles twice, and there are no reads while empty.
- Mid-operation reset: srst_i pulsed at rd_usedw_o = 5 with rd_req_i = 1 -> next edge gives all reset values, and no pointer increment occurs in that cycle.
